// File: rtl/if_id_fifo_if.sv
// Fetch->decode handshake bundle for if_id_fifo; slave is the buffer, master is the fetch/decode side.
interface if_id_fifo_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int INT_W  = 8,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              flush_i;
    logic              hold_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [INST_W-1:0] inst_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic [INT_W-1:0]  int_flag_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic [INT_W-1:0]  int_flag_o;
    logic [CNT_W-1:0]  count_o;

    modport slave (
        input  flush_i, hold_i, in_valid_i, inst_i, inst_addr_i, int_flag_i, out_ready_i,
        output in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
    );

    modport master (
        output flush_i, hold_i, in_valid_i, inst_i, inst_addr_i, int_flag_i, out_ready_i,
        input  in_ready_o, out_valid_o, inst_o, inst_addr_o, int_flag_o, count_o
    );
endinterface

// File: rtl/if_id_fifo.sv
// if_id_fifo: circular IF->ID buffer holding DEPTH {inst, addr, int_flag} entries.
// Latency: 1 cycle push-to-head when empty; head outputs are combinational from storage.
// Backpressure: in_ready_o from registered count only; hold_i blocks pop; flush_i empties.
module if_id_fifo #(
    parameter int                INST_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                INT_W    = 8,
    parameter int                DEPTH    = 2,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
    input  logic        clk,
    input  logic        rst,
    if_id_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("if_id_fifo: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [INT_W-1:0]  int_flag;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic   in_rdy;
    logic   out_vld;
    logic   push;
    logic   pop;
    entry_t in_dat;
    entry_t head_dat;

    // Ready depends only on the registered count, so a same-cycle pop never opens a slot.
    assign in_rdy   = (count_q != CNT_W'(DEPTH));
    assign out_vld  = (count_q != '0);
    assign push     = bus.in_valid_i & in_rdy;
    assign pop      = out_vld & bus.out_ready_i & ~bus.hold_i;
    assign in_dat   = '{inst: bus.inst_i, addr: bus.inst_addr_i, int_flag: bus.int_flag_i};
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count gates every use of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready_o  = in_rdy;
    assign bus.out_valid_o = out_vld;
    assign bus.inst_o      = out_vld ? head_dat.inst     : NOP_INST;
    assign bus.inst_addr_o = out_vld ? head_dat.addr     : '0;
    assign bus.int_flag_o  = out_vld ? head_dat.int_flag : '0;
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo with a queue scoreboard of expected {inst, addr, flag} entries.
module tb_if_id_fifo;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [71:0] sb[$];

    always #5 clk = ~clk;

    if_id_fifo_if #(.INST_W(32), .ADDR_W(32), .INT_W(8), .DEPTH(DEPTH)) bus ();

    if_id_fifo #(.INST_W(32), .ADDR_W(32), .INT_W(8), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, check outputs against the scoreboard, then update the model.
    task automatic step(input logic r, input logic fl, input logic hd, input logic iv,
                        input logic [31:0] addr, input logic [7:0] flg, input logic ordy);
        logic [31:0] inst;
        logic [71:0] head;
        bit          do_push, do_pop;
        inst = $urandom;
        rst             = r;
        bus.flush_i     = fl;
        bus.hold_i      = hd;
        bus.in_valid_i  = iv;
        bus.inst_i      = inst;
        bus.inst_addr_i = addr;
        bus.int_flag_i  = flg;
        bus.out_ready_i = ordy;
        #1;
        chk("count", 72'(bus.count_o), 72'(sb.size()));
        chk("out_valid", 72'(bus.out_valid_o), 72'(sb.size() != 0));
        chk("in_ready", 72'(bus.in_ready_o), 72'(sb.size() < DEPTH));
        head = (sb.size() != 0) ? sb[0] : {NOP, 32'h0, 8'h0};
        chk("head", {bus.inst_o, bus.inst_addr_o, bus.int_flag_o}, head);
        do_push = iv && (sb.size() < DEPTH);
        do_pop  = (sb.size() != 0) && ordy && !hd;
        if (r || fl) begin
            sb.delete();
        end else begin
            if (do_pop)  void'(sb.pop_front());
            if (do_push) sb.push_back({inst, addr, flg});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.flush_i = 0; bus.hold_i = 0; bus.in_valid_i = 0; bus.out_ready_i = 0;
        bus.inst_i = '0; bus.inst_addr_i = '0; bus.int_flag_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", 72'(bus.out_valid_o), 72'(0));
        chk("rst_inst", 72'(bus.inst_o), 72'(NOP));
        chk("rst_ready", 72'(bus.in_ready_o), 72'(1));

        // 1: single entry, one cycle latency then drains
        step(0, 0, 0, 1, 32'h100, 8'h00, 1);
        chk("t1_valid", 72'(bus.out_valid_o), 72'(1));
        chk("t1_addr", 72'(bus.inst_addr_o), 72'(32'h100));
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);
        chk("t1_empty_inst", 72'(bus.inst_o), 72'(NOP));

        // 2: hold fills the buffer, third entry refused and held by fetch
        step(0, 0, 1, 1, 32'h100, 8'h00, 1);
        step(0, 0, 1, 1, 32'h104, 8'h00, 1);
        step(0, 0, 1, 1, 32'h108, 8'h00, 1);
        chk("t2_count", 72'(bus.count_o), 72'(2));
        chk("t2_ready", 72'(bus.in_ready_o), 72'(0));
        chk("t2_head", 72'(bus.inst_addr_o), 72'(32'h100));
        step(0, 0, 0, 1, 32'h108, 8'h00, 1);
        chk("t2_full_pop_no_push", 72'(bus.count_o), 72'(1));
        chk("t2_head2", 72'(bus.inst_addr_o), 72'(32'h104));
        step(0, 0, 0, 1, 32'h108, 8'h00, 1);
        chk("t2_head3", 72'(bus.inst_addr_o), 72'(32'h108));
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);

        // 3: steady stream, pointers wrap several times
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 32'(4 * i), 8'h00, 1);
            chk("t3_count", 72'(bus.count_o), 72'(1));
        end
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);

        // 4: flush with a same-cycle push
        step(0, 0, 0, 1, 32'h200, 8'h00, 0);
        step(0, 0, 0, 1, 32'h204, 8'h00, 0);
        chk("t4_count_pre", 72'(bus.count_o), 72'(2));
        step(0, 1, 0, 1, 32'h208, 8'h00, 1);
        chk("t4_count", 72'(bus.count_o), 72'(0));
        chk("t4_valid", 72'(bus.out_valid_o), 72'(0));
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);

        // 5: int_flag stays with its own entry
        step(0, 0, 0, 1, 32'h300, 8'h01, 0);
        step(0, 0, 0, 1, 32'h304, 8'h00, 0);
        chk("t5_flag_first", 72'(bus.int_flag_o), 72'(8'h01));
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);
        chk("t5_flag_second", 72'(bus.int_flag_o), 72'(8'h00));
        chk("t5_addr_second", 72'(bus.inst_addr_o), 72'(32'h304));
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);

        // 6: reset wins over flush/push/pop while full
        step(0, 0, 0, 1, 32'h400, 8'h02, 0);
        step(0, 0, 0, 1, 32'h404, 8'h03, 0);
        step(1, 1, 0, 1, 32'h408, 8'h04, 1);
        chk("t6_count", 72'(bus.count_o), 72'(0));
        chk("t6_ready", 72'(bus.in_ready_o), 72'(1));
        chk("t6_outs", {bus.inst_o, bus.inst_addr_o, bus.int_flag_o}, {NOP, 32'h0, 8'h0});
        step(0, 0, 0, 0, 32'h0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
